// File: rtl/simple_bus_src.sv
`default_nettype none
// ============================================================================
// Module   : simple_bus_src
// Brief    : Burst source; generates seed-based incrementing words into a FWFT
//            buffer and streams them out over a valid/ready interface.
// Revision : 1.0  initial release
// ============================================================================
module simple_bus_src #(
    parameter int DATA_W     = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_LEN  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sent_cnt
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_OCC_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [7:0]      c_LAST_IDX = 8'(BURST_LEN - 1);
    localparam logic [7:0]      c_CNT_MAX  = 8'd255;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_next_word;
    logic [7:0]        r_gen_cnt;
    logic [7:0]        r_sent_cnt;
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_occ;

    logic w_start;
    logic w_push;
    logic w_pop;
    logic w_last_push;
    logic w_valid;

    // Push is gated on the registered occupancy only, so a simultaneous pop
    // never frees a slot for a push in the same cycle.
    assign w_start     = (r_state == c_IDLE) && start;
    assign w_push      = (r_state == c_FILL) && (r_occ != c_DEPTH);
    assign w_valid     = (r_occ != '0);
    assign w_pop       = w_valid && out_ready;
    assign w_last_push = w_push && (r_gen_cnt == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_next_word <= '0;
            r_gen_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_FILL;
                        r_next_word <= seed;
                        r_gen_cnt   <= '0;
                    end
                end
                c_FILL: begin
                    if (w_push) begin
                        r_next_word <= r_next_word + DATA_W'(1);
                        r_gen_cnt   <= r_gen_cnt + 8'd1;
                        if (w_last_push) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_pop && (r_occ == c_OCC_ONE)) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sent_cnt <= '0;
        end else if (w_start) begin
            r_sent_cnt <= '0;
        end else if (w_pop && (r_sent_cnt != c_CNT_MAX)) begin
            r_sent_cnt <= r_sent_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_ONE;
                2'b01:   r_occ <= r_occ - c_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage is cleared on reset so out_data reads zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= r_next_word;
            r_mem_last[r_wr_ptr] <= (r_gen_cnt == c_LAST_IDX);
        end
    end

    assign out_valid = w_valid;
    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_last  = r_mem_last[r_rd_ptr];
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign sent_cnt  = r_sent_cnt;

endmodule
`default_nettype wire

// File: doc/simple_bus_src.md
SIMPLE_BUS_SRC -- requirements
Module: simple_bus_src

Interface
- REQ-001: Parameter DATA_W, default 7, payload width in bits; legal range 1..32.
- REQ-002: Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, at least 2.
- REQ-003: Parameter BURST_LEN, default 8, words per burst; legal range 1..255.
- REQ-004: Port clk, input, 1 bit, single clock; all state updates on the rising edge.
- REQ-005: Port rst_n, input, 1 bit; reset is synchronous and active-low.
- REQ-006: Port start, input, 1 bit, requests one burst; sampled only in IDLE.
- REQ-007: Port seed, input, DATA_W bits, first payload value; captured with an accepted start.
- REQ-008: Port out_valid, output, 1 bit; buffer head is valid.
- REQ-009: Port out_ready, input, 1 bit; downstream accepts the head.
- REQ-010: Port out_data, output, DATA_W bits; buffer head payload.
- REQ-011: Port out_last, output, 1 bit; head is the final word of the burst.
- REQ-012: Port busy, output, 1 bit; high in every state except IDLE.
- REQ-013: Port done, output, 1 bit; one-cycle pulse at burst completion.
- REQ-014: Port sent_cnt, output, 8 bits; words transferred in the current or most recent burst.

Function
- REQ-015: Shall implement an FSM with states IDLE, FILL, DRAIN and DONE.
- REQ-016: IDLE to FILL when start=1; same edge captures seed and clears the generated-word counter and sent_cnt.
- REQ-017: In FILL, one word shall be pushed per cycle whenever the registered occupancy is below FIFO_DEPTH.
- REQ-018: No push shall occur while occupancy equals FIFO_DEPTH, even if a pop occurs in the same cycle.
- REQ-019: Word i (0-based) shall equal (seed + i) modulo 2^DATA_W, so the sequence wraps silently with no flag.
- REQ-020: The buffer shall store a last bit with each word; it is set only on word BURST_LEN-1.
- REQ-021: FILL to DRAIN on the edge that pushes word BURST_LEN-1.
- REQ-022: DRAIN to DONE on the edge where the last word is popped and occupancy becomes 0.
- REQ-023: DONE shall last one cycle, then return to IDLE; done=1 only in DONE.
- REQ-024: The buffer shall be first-word-fall-through: out_valid = (occupancy != 0), and out_data/out_last come directly from the head entry.
- REQ-025: A pop shall occur exactly when out_valid and out_ready are both 1; push and pop in the same cycle leave occupancy unchanged.
- REQ-026: sent_cnt shall increment by 1 per pop and saturate at 255.
- REQ-027: Latency: start accepted at edge N; first push at edge N+1; out_valid=1 in the cycle after edge N+1.
- REQ-028: With out_ready held at 1, a burst of BURST_LEN words shall complete with done at edge N+BURST_LEN+2.
- REQ-029: out_data and out_last shall stay stable while out_valid=1 and out_ready=0.
- REQ-030: start shall be ignored while busy=1; no restart and no change to the captured seed.

Reset
- REQ-031: On an edge with rst_n=0, state shall become IDLE and occupancy, read pointer, write pointer, word counter and sent_cnt shall become 0.
- REQ-032: Output reset values: out_valid=0, out_last=0, busy=0, done=0, sent_cnt=0, out_data=0.
- REQ-033: Reset mid-burst shall discard all buffered words; start in the first cycle after release shall be honoured.

Verification
- REQ-034: Defaults, seed=5, out_ready=1 -> data 5..12, out_last only on 12, done at start edge +10, sent_cnt=8.
- REQ-035: seed=125, DATA_W=7 -> data 125,126,127,0,1,2,3,4; no error indication.
- REQ-036: out_ready=0 for 10 cycles after start -> occupancy stalls at 4 with head=seed; releasing out_ready delivers all 8 words in order.
- REQ-037: out_ready toggling every cycle plus a start pulse while busy -> burst is unaffected and exactly 8 words are sent.
- REQ-038: rst_n=0 for one edge after 3 pops -> out_valid=0, sent_cnt=0; a new burst with seed=0 then yields 0..7.
- REQ-039: BURST_LEN=1, seed=9 -> a single word 9 with out_last=1, and done 3 edges after start.
